// File: rtl/sdram_port_stub.sv
// Block-RAM stand-in for the SDRAM controller user-side write/read port.
// Optional read-data corruption hook is built only when SDRAM_STUB_ERR_INJECT_EN is defined.
`timescale 1ns/1ps
module sdram_port_stub #(
   parameter int DW          = 16,
   parameter int AW          = 15,
   parameter int INIT_CYCLES = 10000,
   parameter int RD_LATENCY  = 1
) (
   input  logic          clk_50m,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          sdram_init_done,
   output logic [AW:0]   wr_level,
   output logic          overrun,
   output logic          underrun,
   input  logic          err_inject
);

   localparam int            DEPTH      = 2**AW;
   localparam int            CW         = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CW-1:0] INIT_LAST  = CW'(INIT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
   localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LEVEL_FULL = {1'b1, {AW{1'b0}}};

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] init_cnt_q, init_cnt_d;
   logic          init_done_q, init_done_d;

   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [AW:0]   wr_level_q, wr_level_d;
   logic          overrun_q, overrun_d;
   logic          underrun_q, underrun_d;

   logic          wr_fire, rd_fire;
   logic          inj_bit;
   logic [DW-1:0] flip_mask;

   logic [DW-1:0]       mem [DEPTH];
   logic [DW-1:0]       pipe_data_q [1:RD_LATENCY];
   logic [RD_LATENCY:1] pipe_vld_q;
   logic [RD_LATENCY:1] stage_load;

   // ---------------- init FSM ----------------
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_INIT;
         init_cnt_q  <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         init_done_q <= init_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
      unique case (state_q)
         S_INIT: begin
            init_cnt_d = init_cnt_q + CNT_ONE;
            if (init_cnt_q == INIT_LAST) begin
               state_d     = S_READY;
               init_done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ---------------- addressing, level and sticky flags ----------------
   assign wr_fire = (state_q == S_READY) && wr_en;
   assign rd_fire = (state_q == S_READY) && rd_en;

   always_comb begin
      wr_addr_d  = wr_addr_q;
      rd_addr_d  = rd_addr_q;
      wr_level_d = wr_level_q;
      overrun_d  = overrun_q;
      underrun_d = underrun_q;
      if (wr_fire) begin
         wr_addr_d = wr_addr_q + ADDR_ONE;
         if (wr_level_q == LEVEL_FULL) overrun_d = 1'b1;
         else                          wr_level_d = wr_level_q + LEVEL_ONE;
      end
      // reads replay the buffer; they never consume level
      if (rd_fire) begin
         rd_addr_d = rd_addr_q + ADDR_ONE;
         if (wr_level_q == '0) underrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         wr_level_q <= '0;
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         wr_addr_q  <= wr_addr_d;
         rd_addr_q  <= rd_addr_d;
         wr_level_q <= wr_level_d;
         overrun_q  <= overrun_d;
         underrun_q <= underrun_d;
      end
   end

   // ---------------- RAM and read pipeline ----------------
   always_ff @(posedge clk_50m) begin
      if (wr_fire) mem[wr_addr_q] <= wr_data;
   end

   always_comb begin
      stage_load[1] = rd_fire;
      for (int unsigned i = 2; i <= RD_LATENCY; i++) stage_load[i] = pipe_vld_q[i-1];
   end

   assign flip_mask = DW'(inj_bit);

   // stage 1 is the RAM output register; corruption lands only on the final stage load
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld_q <= '0;
         for (int unsigned i = 1; i <= RD_LATENCY; i++) pipe_data_q[i] <= '0;
      end else begin
         pipe_vld_q <= stage_load;
         if (stage_load[1])
            pipe_data_q[1] <= mem[rd_addr_q] ^ ((RD_LATENCY == 1) ? flip_mask : '0);
         for (int unsigned i = 2; i <= RD_LATENCY; i++) begin
            if (stage_load[i])
               pipe_data_q[i] <= pipe_data_q[i-1] ^ ((i == RD_LATENCY) ? flip_mask : '0);
         end
      end
   end

`ifdef SDRAM_STUB_ERR_INJECT_EN
   logic inj_armed_q;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n)                        inj_armed_q <= 1'b0;
      else if (stage_load[RD_LATENCY])   inj_armed_q <= 1'b0;
      else if (err_inject)               inj_armed_q <= 1'b1;
   end

   assign inj_bit = inj_armed_q | err_inject;
`else
   logic unused_err_inject;

   assign unused_err_inject = err_inject;
   assign inj_bit           = 1'b0;
`endif

   assign rd_data         = pipe_data_q[RD_LATENCY];
   assign rd_valid        = pipe_vld_q[RD_LATENCY];
   assign sdram_init_done = init_done_q;
   assign wr_level        = wr_level_q;
   assign overrun         = overrun_q;
   assign underrun        = underrun_q;

endmodule

// File: tb/tb_sdram_port_stub.sv
// Scoreboard bench for sdram_port_stub: latency-1 and latency-3 instances share stimulus,
// each checked by its own monitor against a queue-based reference model.
`timescale 1ns/1ps
module tb_sdram_port_stub;

   localparam int DW    = 16;
   localparam int AW    = 15;
   localparam int INIT  = 10000;
   localparam int DEPTH = 2**AW;

   typedef struct {
      logic [DW-1:0] d;
      bit            care;
      int            due;
   } exp_t;

   logic clk_50m = 1'b0;
   always #10 clk_50m = ~clk_50m;

   logic          rst_n, wr_en, rd_en, err_inject;
   logic [DW-1:0] wr_data;

   logic [DW-1:0] rd_data1, rd_data3;
   logic          rd_valid1, rd_valid3, done1, done3;
   logic          ovr1, ovr3, und1, und3;
   logic [AW:0]   lvl1, lvl3;

   sdram_port_stub #(.DW(DW), .AW(AW), .INIT_CYCLES(INIT), .RD_LATENCY(1)) dut1 (
      .clk_50m(clk_50m), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .sdram_init_done(done1), .wr_level(lvl1),
      .overrun(ovr1), .underrun(und1), .err_inject(err_inject));

   sdram_port_stub #(.DW(DW), .AW(AW), .INIT_CYCLES(INIT), .RD_LATENCY(3)) dut3 (
      .clk_50m(clk_50m), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data3), .rd_valid(rd_valid3), .sdram_init_done(done3), .wr_level(lvl3),
      .overrun(ovr3), .underrun(und3), .err_inject(err_inject));

   int          edge_cnt = 0;
   int          rel_edge = 0;
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always @(posedge clk_50m) edge_cnt <= edge_cnt + 1;

   // reference model: plain buffer with pointers modulo DEPTH
   logic [DW-1:0] m_mem [DEPTH];
   int unsigned   m_level, m_wr, m_rd;
   bit            m_over, m_under, m_armed;
   exp_t          q1[$], q3[$];
   exp_t          x1, x3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
   endtask

   task automatic model_reset();
      m_level = 0; m_wr = 0; m_rd = 0;
      m_over = 1'b0; m_under = 1'b0; m_armed = 1'b0;
      q1.delete(); q3.delete();
   endtask

   // apply inputs for one edge, advance the model for that edge, return at the next negedge
   task automatic tick(input bit w, input logic [DW-1:0] wd, input bit r, input bit inj);
      int   e;
      exp_t x;
      wr_en = w; wr_data = wd; rd_en = r; err_inject = inj;
      e = edge_cnt + 1;
      if (e - rel_edge > INIT) begin
`ifdef SDRAM_STUB_ERR_INJECT_EN
         if (inj) m_armed = 1'b1;
`endif
         if (r) begin
            x.d    = m_mem[m_rd];
            x.care = (m_level != 0);
            if (m_level == 0) m_under = 1'b1;
            if (m_armed) begin
               x.d[0]  = ~x.d[0];
               m_armed = 1'b0;
            end
            m_rd  = (m_rd + 1) % DEPTH;
            x.due = e;     q1.push_back(x);
            x.due = e + 2; q3.push_back(x);
         end
         if (w) begin
            m_mem[m_wr] = wd;
            m_wr = (m_wr + 1) % DEPTH;
            if (m_level == DEPTH) m_over = 1'b1;
            else                  m_level++;
         end
      end
      @(posedge clk_50m);
      @(negedge clk_50m);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_lvl1"}, 32'(lvl1), m_level);
      check({tag, "_lvl3"}, 32'(lvl3), m_level);
      check({tag, "_ovr1"}, ovr1, m_over);
      check({tag, "_ovr3"}, ovr3, m_over);
      check({tag, "_und1"}, und1, m_under);
      check({tag, "_und3"}, und3, m_under);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rdv1"}, rd_valid1, 1'b0);
      check({tag, "_rdv3"}, rd_valid3, 1'b0);
      check({tag, "_done1"}, done1, 1'b0);
      check({tag, "_done3"}, done3, 1'b0);
      check({tag, "_lvl1"}, 32'(lvl1), 32'd0);
      check({tag, "_ovr1"}, ovr1, 1'b0);
      check({tag, "_und3"}, und3, 1'b0);
   endtask

   task automatic release_reset();
      @(negedge clk_50m);
      rst_n    = 1'b1;
      rel_edge = edge_cnt;
      model_reset();
   endtask

   // run through the init window with ignored strobes, checking the done edge each cycle
   task automatic run_init();
      for (int i = 0; i < INIT + 2; i++) begin
         if (i < INIT)
            tick($urandom_range(0, 3) == 0, DW'($urandom), $urandom_range(0, 3) == 0, 1'b0);
         else
            tick(1'b0, '0, 1'b0, 1'b0);
         check("init_done1", done1, (edge_cnt - rel_edge) >= INIT);
         check("init_done3", done3, (edge_cnt - rel_edge) >= INIT);
      end
      check_state("post_init");
   endtask

   task automatic drain();
      repeat (4) tick(1'b0, '0, 1'b0, 1'b0);
   endtask

   always @(negedge clk_50m) begin
      if (rst_n) begin
         if (q1.size() > 0 && q1[0].due == edge_cnt) begin
            x1 = q1.pop_front();
            check("lat1_valid", rd_valid1, 1'b1);
            if (x1.care) check("lat1_data", 32'(rd_data1), 32'(x1.d));
         end else if (rd_valid1) begin
            check("lat1_spurious_valid", rd_valid1, 1'b0);
         end
      end
   end

   always @(negedge clk_50m) begin
      if (rst_n) begin
         if (q3.size() > 0 && q3[0].due == edge_cnt) begin
            x3 = q3.pop_front();
            check("lat3_valid", rd_valid3, 1'b1);
            if (x3.care) check("lat3_data", 32'(rd_data3), 32'(x3.d));
         end else if (rd_valid3) begin
            check("lat3_spurious_valid", rd_valid3, 1'b0);
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_inject = 1'b0; wr_data = '0;
      model_reset();
      repeat (3) @(negedge clk_50m);
      #1 check_reset_values("por");
      check("por_rdata1", 32'(rd_data1), 32'd0);
      check("por_rdata3", 32'(rd_data3), 32'd0);

      release_reset();
      run_init();

      // underrun: single read with nothing written
      tick(1'b0, '0, 1'b1, 1'b0);
      drain();
      check_state("underrun");

      // reset in the middle of a read burst
      n = $urandom_range(4, 8);
      for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b1, 1'b0);
      #1 rst_n = 1'b0;
      #1 check_reset_values("mid_read_rst");
      rd_en = 1'b0;
      model_reset();
      repeat (3) @(negedge clk_50m);
      release_reset();
      run_init();

      // loopback fill 1..DEPTH
      for (int i = 0; i < DEPTH; i++) tick(1'b1, DW'(i + 1), 1'b0, 1'b0);
      check_state("filled");

      // read past the wrap; the first read collides with an overrunning write to address 0
      for (int i = 0; i < DEPTH + 2; i++) tick(i == 0, 16'hBEEF, 1'b1, 1'b0);
      drain();
      check_state("wrap_overrun");

      // random mixed traffic
      for (int i = 0; i < 400; i++) begin
`ifdef SDRAM_STUB_ERR_INJECT_EN
         tick($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 1) == 1, 1'b0);
`else
         tick($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 1) == 1,
              $urandom_range(0, 7) == 0);
`endif
      end
      drain();
      check_state("random");

`ifdef SDRAM_STUB_ERR_INJECT_EN
      tick(1'b1, 16'd5, 1'b0, 1'b0);
      tick(1'b1, 16'd6, 1'b0, 1'b0);
      tick(1'b1, 16'd7, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b1);
      tick(1'b0, '0, 1'b0, 1'b1);
      tick(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0);
      drain();
      check_state("err_inject");
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
